// File: rtl/ipc_doorbell_ctrl_if.sv
// Single-beat AXI4-Lite port used by the doorbell poller.
// The master side is the poller; the slave side is the interconnect.
interface ipc_doorbell_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready,
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready,
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/ipc_doorbell_ctrl.sv
// Doorbell poller: reads the host doorbell word, kicks ipc_get when it is
// nonzero, waits for ipc_get to go idle again, then writes the doorbell to 0.
module ipc_doorbell_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] DOORBELL_ADDR = ADDR_WIDTH'(32'h0000_1000),
    parameter int POLL_INTERVAL = 1000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ENABLE,
    output logic        GET_START,
    input  logic        GET_IDLE,
    output logic        BUSY,
    output logic [31:0] MSG_COUNT,
    output logic        ERROR,
    ipc_doorbell_ctrl_if.master axi
);

    localparam int CW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(POLL_INTERVAL - 1);

    typedef enum logic [2:0] {
        POLL_WAIT,
        RD_ADDR,
        RD_DATA,
        START_GET,
        WAIT_GET,
        WR_REQ,
        WR_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          arvalid_q, arvalid_d;
    logic          rready_q, rready_d;
    logic          awvalid_q, awvalid_d;
    logic          wvalid_q, wvalid_d;
    logic          bready_q, bready_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;
    logic          start_q, start_d;
    logic [31:0]   msg_q, msg_d;
    logic          err_q, err_d;
    logic          aw_hs, w_hs;

    assign aw_hs = awvalid_q & axi.awready;
    assign w_hs  = wvalid_q & axi.wready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= POLL_WAIT;
            cnt_q     <= RELOAD;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            start_q   <= 1'b0;
            msg_q     <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            start_q   <= start_d;
            msg_q     <= msg_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        start_d   = 1'b0;
        msg_d     = msg_q;
        err_d     = err_q;
        unique case (state_q)
            POLL_WAIT: begin
                if (ENABLE) begin
                    if (cnt_q == '0) begin
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            RD_ADDR: begin
                if (axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (axi.rvalid) begin
                    rready_d = 1'b0;
                    if (axi.rresp != 2'b00) begin
                        err_d   = 1'b1;
                        cnt_d   = RELOAD;
                        state_d = POLL_WAIT;
                    end else if (axi.rdata == '0) begin
                        cnt_d   = RELOAD;
                        state_d = POLL_WAIT;
                    end else begin
                        start_d = 1'b1;
                        state_d = START_GET;
                    end
                end
            end
            START_GET: begin
                state_d = WAIT_GET;
            end
            WAIT_GET: begin
                // ipc_get is already busy by the time this is first sampled
                if (GET_IDLE) begin
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WR_REQ;
                end
            end
            WR_REQ: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (axi.bvalid) begin
                    bready_d = 1'b0;
                    if (axi.bresp == 2'b00) begin
                        msg_d = msg_q + 32'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                    cnt_d   = RELOAD;
                    state_d = POLL_WAIT;
                end
            end
            default: begin
                state_d = POLL_WAIT;
            end
        endcase
    end

    assign GET_START   = start_q;
    assign BUSY        = (state_q != POLL_WAIT);
    assign MSG_COUNT   = msg_q;
    assign ERROR       = err_q;

    assign axi.araddr  = DOORBELL_ADDR;
    assign axi.arprot  = 3'b000;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;
    assign axi.awaddr  = DOORBELL_ADDR;
    assign axi.awprot  = 3'b000;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = '0;
    assign axi.wstrb   = {(DATA_WIDTH/8){1'b1}};
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;

endmodule
